// File: rtl/fiber_evt_arbiter_if.sv
// Event-path bundle between the per-channel FWFT buffers, the arbiter and the
// Aurora outbound event FIFO. The arbiter takes the master modport.
interface fiber_evt_arbiter_if #(
    parameter int NCH = 2,
    parameter int DW  = 32
);
    logic [NCH-1:0]    IN_EMPTY;
    logic [NCH*DW-1:0] IN_DATA;
    logic [NCH-1:0]    IN_RD;
    logic              OUT_FULL;
    logic              OUT_WR;
    logic [DW-1:0]     OUT_DATA;
    logic              OUT_END;

    modport master (
        input  IN_EMPTY, IN_DATA, OUT_FULL,
        output IN_RD, OUT_WR, OUT_DATA, OUT_END
    );

    modport slave (
        output IN_EMPTY, IN_DATA, OUT_FULL,
        input  IN_RD, OUT_WR, OUT_DATA, OUT_END
    );
endinterface

// File: rtl/fiber_evt_arbiter.sv
// Round-robin block arbiter: NCH FWFT event FIFOs into one Aurora event FIFO,
// each block closed by an END word. FIBER_EVT_MAXLEN_EN adds block-length truncation.
module fiber_evt_arbiter #(
    parameter int         NCH       = 2,
    parameter int         DW        = 32,
    parameter int         TRL_POS   = 20,
    parameter logic [3:0] TRL_CODE  = 4'h2,
    parameter int         MAX_WORDS = 4096
) (
    input  logic                                   CLK,
    input  logic                                   RSTb,
    input  logic                                   ENABLE,
    fiber_evt_arbiter_if.master                    bus,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] OUT_CH,
    output logic                                   BUSY,
    output logic [15:0]                            BLK_COUNT,
    output logic [15:0]                            TRUNC_COUNT
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_XFER,
`ifdef FIBER_EVT_MAXLEN_EN
        S_DRAIN,
`endif
        S_END
    } state_t;

    state_t        state;
    logic [CW-1:0] last_grant;
    logic [CW-1:0] pick;
    logic [CW-1:0] cand;
    logic          found;
    logic [DW-1:0] g_data;
    logic          g_empty;
    logic          is_trl;
    logic          move;

`ifdef FIBER_EVT_MAXLEN_EN
    localparam int WCW = $clog2(MAX_WORDS + 1);
    logic [WCW-1:0] wcnt;
    logic           trunc;
    logic [15:0]    trunc_q;
    assign TRUNC_COUNT = trunc_q;
`else
    assign TRUNC_COUNT = '0;
`endif

    // Round-robin search starts just above the previous winner.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = CW'((int'(last_grant) + k) % NCH);
            if (!found && !bus.IN_EMPTY[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        g_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (OUT_CH == CW'(i)) g_data = bus.IN_DATA[i*DW +: DW];
        end
    end

    assign g_empty = bus.IN_EMPTY[OUT_CH];
    assign is_trl  = (g_data[TRL_POS +: 4] == TRL_CODE);
    assign move    = (state == S_XFER) && !g_empty && !bus.OUT_FULL;

    always_comb begin
        bus.IN_RD    = '0;
        bus.OUT_WR   = 1'b0;
        bus.OUT_END  = 1'b0;
        bus.OUT_DATA = '0;
        case (state)
            S_XFER: begin
                bus.IN_RD[OUT_CH] = move;
                bus.OUT_WR        = move;
                bus.OUT_DATA      = g_data;
            end
`ifdef FIBER_EVT_MAXLEN_EN
            S_DRAIN: bus.IN_RD[OUT_CH] = !g_empty;
`endif
            S_END: begin
                bus.OUT_WR  = !bus.OUT_FULL;
                bus.OUT_END = !bus.OUT_FULL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        // NOTE: registered state uses non-blocking assignments only.
        if (!RSTb) begin
            state      <= S_IDLE;
            last_grant <= CW'(NCH - 1);
            OUT_CH     <= '0;
            BUSY       <= 1'b0;
            BLK_COUNT  <= '0;
`ifdef FIBER_EVT_MAXLEN_EN
            wcnt       <= '0;
            trunc      <= 1'b0;
            trunc_q    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (ENABLE && !(&bus.IN_EMPTY)) begin
                        state <= S_ARB;
                        BUSY  <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (found) begin
                        OUT_CH     <= pick;
                        last_grant <= pick;
                        state      <= S_XFER;
`ifdef FIBER_EVT_MAXLEN_EN
                        wcnt       <= '0;
`endif
                    end else begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                S_XFER: begin
                    if (move) begin
`ifdef FIBER_EVT_MAXLEN_EN
                        wcnt <= wcnt + 1'b1;
                        if (is_trl) begin
                            state <= S_END;
                        end else if (wcnt == WCW'(MAX_WORDS - 1)) begin
                            state <= S_DRAIN;
                            trunc <= 1'b1;
                        end
`else
                        if (is_trl) state <= S_END;
`endif
                    end
                end
`ifdef FIBER_EVT_MAXLEN_EN
                S_DRAIN: begin
                    if (!g_empty && is_trl) state <= S_END;
                end
`endif
                S_END: begin
                    if (!bus.OUT_FULL) begin
                        BLK_COUNT <= BLK_COUNT + 16'd1;
`ifdef FIBER_EVT_MAXLEN_EN
                        if (trunc) trunc_q <= trunc_q + 16'd1;
                        trunc <= 1'b0;
`endif
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
